instr_fetch_queue: RTL and testbench

- Upstream fetch stage for the RV32I core.
- Generates sequential instruction-memory requests over a valid/ready request channel with an in-order response channel.
- Buffers returned instruction words with their PCs in a small FIFO and presents them to decode via valid/ready.
- Handles branch/jump redirects: flushes buffered words, restarts fetch at the target PC, and discards responses still in flight from the old path.

---
 rtl/instr_fetch_queue.sv | 130 +++++++++++++
 tb/tb_instr_fetch_queue.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - RV32I fetch stage: sequential imem requests, PC-tagged instruction queue, redirect flush
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    // Counters must hold the value DEPTH itself, pointers only index entries.
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam int              PW      = $clog2(DEPTH);
    localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);

    // Architectural state.
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   word_mem [DEPTH];

    // Per-cycle events.
    logic [CW:0]   in_flight;
    logic          req_fire;
    logic          rsp_keep;
    logic          pop;
    logic [CW-1:0] req_inc;
    logic [CW-1:0] rsp_dec;
    logic [31:0]   redirect_target;

    // Issue/dequeue handshakes; a slot is reserved for every request so responses never overflow.
    always_comb begin
        in_flight       = {1'b0, count} + {1'b0, outstanding};
        redirect_target = {redirect_pc[31:2], 2'b00};

        imem_req_valid  = !rst && !redirect_valid && (in_flight < DEPTH_W);
        imem_req_addr   = fetch_pc;
        req_fire        = imem_req_valid && imem_req_ready;

        // Responses in the redirect cycle belong to the old path and are never kept.
        rsp_keep        = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);

        instr_valid     = (count != '0) && !redirect_valid;
        instr           = (count != '0) ? word_mem[rd_ptr] : 32'h0000_0000;
        instr_pc        = (count != '0) ? pc_mem[rd_ptr]   : 32'h0000_0000;
        pop             = instr_valid && instr_ready;

        req_inc         = CW'(req_fire);
        rsp_dec         = CW'(imem_rsp_valid);
    end

    // Control state: reset, then redirect flush, then normal fetch/response/pop bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            // Every response retires one outstanding request, kept or dropped.
            outstanding <= outstanding + req_inc - rsp_dec;

            if (redirect_valid) begin
                // Everything still owed by memory after this cycle is old-path and must be dropped.
                fetch_pc <= redirect_target;
                rsp_pc   <= redirect_target;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                drop_cnt <= outstanding - rsp_dec;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end

                // Kept responses arrive in request order, so their PC simply advances by one word.
                if (rsp_keep) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    rsp_pc <= rsp_pc + 32'd4;
                end

                if (imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CNT_ONE;
                end

                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end

                count <= count + CW'(rsp_keep) - CW'(pop);
            end
        end
    end

    // Queue storage: {pc, word} written at the tail for each kept response.
    always_ff @(posedge clk) begin
        if (!rst && rsp_keep) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            word_mem[wr_ptr] <= imem_rsp_data;
        end
    end

    // Memory must never answer more requests than were issued.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rsp_valid && (outstanding == '0)));
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard bench for instr_fetch_queue
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    exp_t        sb[$];
    pend_t       pending[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    int          delivered = 0;
    int          fires = 0;
    int          max_pending = 0;
    int          exp_drop = 0;
    int          d0;
    logic [31:0] exp_addr = RESET_PC;
    logic        await_first = 1'b0;
    logic [31:0] first_pc = '0;
    logic [31:0] last_pc = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_delivered(input int target, input int budget, input string tag);
        int k = 0;
        while (delivered < target && k < budget) begin
            step(1);
            k++;
        end
        if (delivered < target) check_eq(tag, 32'(delivered), 32'(target));
    endtask

    task automatic wait_first(input string tag);
        int k = 0;
        while (await_first && k < 200) begin
            step(1);
            k++;
        end
        if (await_first) check_eq(tag, 32'(await_first), 32'd0);
    endtask

    // Memory model: in-order responses, fixed latency per request.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (pending.size() > 0 && pending[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pending[0].addr);
                void'(pending.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    // Monitor: checks request addresses, pushes expected words, pops/compares deliveries.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            pending.delete();
            exp_addr = RESET_PC;
        end else if (redirect_valid) begin
            check_eq("redir_no_req", 32'(imem_req_valid), 32'd0);
            check_eq("redir_no_pop", 32'(instr_valid), 32'd0);
            // Responses still owed after this cycle (the one arriving now is already gone from pending).
            exp_drop    = pending.size();
            sb.delete();
            exp_addr    = {redirect_pc[31:2], 2'b00};
            await_first = 1'b1;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                check_eq("req_addr", imem_req_addr, exp_addr);
                e.pc   = exp_addr;
                e.word = mem_word(exp_addr);
                sb.push_back(e);
                pending.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
                exp_addr = exp_addr + 32'd4;
                fires++;
                if (pending.size() > max_pending) max_pending = pending.size();
            end
            if (instr_valid && instr_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check_eq("instr_pc", instr_pc, e.pc);
                    check_eq("instr_word", instr, e.word);
                end
                delivered++;
                last_pc = instr_pc;
                if (await_first) begin
                    first_pc    = instr_pc;
                    await_first = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;

        // Reset values and first-request/first-instruction latency.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_instr_pc", instr_pc, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("first_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("first_req_addr", imem_req_addr, RESET_PC);
        check_eq("lat_c0_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check_eq("lat_c1_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check_eq("lat_c2_valid", 32'(instr_valid), 32'd1);
        check_eq("lat_c2_pc", instr_pc, RESET_PC);
        @(posedge clk);
        #1;

        // One instruction per cycle with 1-cycle memory.
        step(5);
        d0 = delivered;
        step(10);
        check_eq("throughput_l1", 32'(delivered - d0), 32'd10);

        // 3-cycle memory, 100 instructions, bounded outstanding.
        mem_lat     = 3;
        max_pending = 0;
        d0          = delivered;
        wait_delivered(d0 + 100, 1000, "l3_timeout");
        check_eq("max_outstanding", 32'(max_pending <= DEPTH), 32'd1);

        // Random backpressure on both sides.
        mem_lat = 2;
        for (int i = 0; i < 400; i++) begin
            instr_ready    = ($urandom_range(0, 1) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        instr_ready    = 1'b1;
        imem_req_ready = 1'b1;
        d0 = delivered;
        wait_delivered(d0 + 20, 200, "rand_recover");

        // Redirect with exactly two requests outstanding and no response that cycle.
        mem_lat        = 3;
        imem_req_ready = 1'b0;
        for (int k = 0; k < 200 && (sb.size() != 0 || pending.size() != 0); k++) step(1);
        check_eq("drain_sb", 32'(sb.size()), 32'd0);
        instr_ready    = 1'b0;
        imem_req_ready = 1'b1;
        step(2);
        imem_req_ready = 1'b0;
        check_eq("two_outstanding", 32'(pending.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step(1);
        redirect_valid = 1'b0;
        check_eq("drop_cnt_two", 32'(dut.drop_cnt), 32'd2);
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        wait_first("redir_e_timeout");
        check_eq("redir_first_pc", first_pc, 32'h0000_0100);

        // Redirect colliding with a pop and an arriving response.
        mem_lat = 2;
        step(10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step(1);
        redirect_valid = 1'b0;
        check_eq("drop_cnt_collide", 32'(dut.drop_cnt), 32'(exp_drop));
        check_eq("drop_cnt_nonzero", 32'(dut.drop_cnt != 0), 32'd1);
        wait_first("redir_f_timeout");
        check_eq("collide_first_pc", first_pc, 32'h0000_0200);

        // Fetch address wrap at the top of the address space.
        mem_lat = 1;
        step(5);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step(1);
        redirect_valid = 1'b0;
        wait_first("wrap_timeout");
        check_eq("wrap_first_pc", first_pc, 32'hFFFF_FFFC);
        d0 = delivered;
        wait_delivered(d0 + 1, 50, "wrap_next_timeout");
        check_eq("wrap_next_pc", last_pc, 32'h0000_0000);

        // Reset mid-stream, then a stalled decode fills exactly DEPTH slots.
        step(5);
        rst         = 1'b1;
        instr_ready = 1'b0;
        step(1);
        check_eq("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("midrst_instr_valid", 32'(instr_valid), 32'd0);
        step(1);
        rst   = 1'b0;
        fires = 0;
        step(12);
        check_eq("stall_fires", 32'(fires), 32'(DEPTH));
        check_eq("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("stall_instr_valid", 32'(instr_valid), 32'd1);
        check_eq("stall_head_pc", instr_pc, RESET_PC);
        check_eq("stall_sb_size", 32'(sb.size()), 32'(DEPTH));
        instr_ready = 1'b1;
        d0 = delivered;
        wait_delivered(d0 + 10, 100, "stall_release");
        check_eq("resume_fires", 32'(fires > DEPTH), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
